// File: rtl/haze_pkg.sv
// Shared constants and the Q0.16 reciprocal used by the haze-removal stages.
package haze_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int Q016_W    = 16;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;
  localparam int N_PIX     = IMG_W_DEF * IMG_H_DEF;

  // floor(2^16 / x), saturated to the Q0.16 full-scale value; x == 0 saturates too.
  function automatic logic [Q016_W-1:0] recip_q016(input int unsigned x);
    int unsigned q;
    if (x == 0) q = 32'h0000_FFFF;
    else        q = 32'h0001_0000 / x;
    if (q > 32'h0000_FFFF) q = 32'h0000_FFFF;
    return q[Q016_W-1:0];
  endfunction

endpackage

// File: rtl/ale_min_tree.sv
// Balanced N-input, W-bit combinational minimum tree built by recursive halving.
module ale_min_tree #(
  parameter int N = 9,
  parameter int W = 8
) (
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_min
);

  generate
    if (N == 1) begin : g_leaf
      assign o_min = i_data;
    end else begin : g_node
      localparam int NL = N / 2;
      localparam int NH = N - NL;
      logic [W-1:0] w_min_lo;
      logic [W-1:0] w_min_hi;

      ale_min_tree #(.N(NL), .W(W)) u_lo (
        .i_data (i_data[NL*W-1:0]),
        .o_min  (w_min_lo)
      );

      ale_min_tree #(.N(NH), .W(W)) u_hi (
        .i_data (i_data[N*W-1:NL*W]),
        .o_min  (w_min_hi)
      );

      assign o_min = (w_min_hi < w_min_lo) ? w_min_hi : w_min_lo;
    end
  endgenerate

endmodule

// File: rtl/ale_frame_param.sv
// Frame-aware atmospheric light estimator: window min -> dark channel -> per-frame brightest pick -> commit.
// Optional temporal smoothing of the committed A across frames when ALE_IIR_EN is defined.
module ale_frame_param
  import haze_pkg::*;
#(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int WIN    = 3,
  parameter int A_MIN  = 16,
  parameter int IIR_SH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [WIN*WIN*3*PIX_W-1:0]   in_win,
  output logic [PIX_W-1:0]             a_r,
  output logic [PIX_W-1:0]             a_g,
  output logic [PIX_W-1:0]             a_b,
  output logic [Q016_W-1:0]            inv_a_r,
  output logic [Q016_W-1:0]            inv_a_g,
  output logic [Q016_W-1:0]            inv_a_b,
  output logic                         a_valid,
  output logic                         frame_err
);

  localparam int NWIN  = WIN * WIN;
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int A_TOP = (2 ** PIX_W) - 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
  localparam logic [PIX_W-1:0]  A_FLOOR  = PIX_W'(A_MIN);
  localparam logic [PIX_W-1:0]  A_RST    = PIX_W'(A_TOP);
  localparam logic [Q016_W-1:0] INV_RST  = recip_q016(A_TOP);

  generate
    if (A_MIN < 1 || A_MIN > A_TOP || IIR_SH < 0 || IIR_SH > PIX_W) begin : g_bad_param
      $error("ale_frame_param: A_MIN must be in [1, 2^PIX_W-1] and IIR_SH in [0, PIX_W]");
    end
  endgenerate

  // Channel 0 = R, 1 = G, 2 = B throughout.
  logic [NWIN*PIX_W-1:0] w_vec    [3];
  logic [PIX_W-1:0]      w_min    [3];
  logic [PIX_W-1:0]      r_min1   [3];
  logic [PIX_W-1:0]      r_run    [3];
  logic [PIX_W-1:0]      w_cl     [3];
  logic [PIX_W-1:0]      w_a_new  [3];
  logic [Q016_W-1:0]     w_inv_new[3];
  logic [PIX_W-1:0]      r_a      [3];
  logic [Q016_W-1:0]     r_inv    [3];
  logic [Q016_W-1:0]     w_lut    [2**PIX_W];

  logic                  r_v1;
  logic                  r_sof1;
  logic [CNT_W-1:0]      r_cnt;
  logic [PIX_W-1:0]      r_run_max;
  logic                  r_done;
  logic                  r_frame_err;
  logic                  r_a_valid;
  logic                  w_commit;

  // Reciprocal ROM, indexed by the committed channel value.
  generate
    for (genvar gi = 0; gi < 2**PIX_W; gi++) begin : g_lut
      assign w_lut[gi] = recip_q016(gi);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      for (genvar gk = 0; gk < NWIN; gk++) begin : g_pix
        assign w_vec[gi][gk*PIX_W +: PIX_W] = in_win[gk*3*PIX_W + (2-gi)*PIX_W +: PIX_W];
      end

      ale_min_tree #(.N(NWIN), .W(PIX_W)) u_min (
        .i_data (w_vec[gi]),
        .o_min  (w_min[gi])
      );

      assign w_cl[gi]      = (r_run[gi] < A_FLOOR) ? A_FLOOR : r_run[gi];
      assign w_inv_new[gi] = w_lut[w_a_new[gi]];
    end
  endgenerate

  // S1: per-channel window minimum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_sof1 <= 1'b0;
      for (int c = 0; c < 3; c++) r_min1[c] <= '0;
    end else begin
      r_v1   <= in_valid;
      r_sof1 <= in_valid & in_sof;
      if (in_valid) begin
        for (int c = 0; c < 3; c++) r_min1[c] <= w_min[c];
      end
    end
  end

  // S2: dark channel and running brightest-pixel tracking.
  logic [PIX_W-1:0] w_dark_rg;
  logic [PIX_W-1:0] w_dark;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_take;
  logic             w_last;
  logic             w_restart;

  assign w_dark_rg  = (r_min1[1] < r_min1[0]) ? r_min1[1] : r_min1[0];
  assign w_dark     = (r_min1[2] < w_dark_rg) ? r_min1[2] : w_dark_rg;
  assign w_restart  = r_sof1 && (r_cnt != '0);
  // A start-of-frame window always begins a fresh count, discarding any partial frame.
  assign w_cnt_base = r_sof1 ? '0 : r_cnt;
  assign w_take     = (w_cnt_base == '0) || (w_dark > r_run_max);
  assign w_last     = (w_cnt_base == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      for (int c = 0; c < 3; c++) r_run[c] <= '0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_v1) begin
        r_frame_err <= w_restart;
        if (w_take) begin
          for (int c = 0; c < 3; c++) r_run[c] <= r_min1[c];
        end
        if (w_last) begin
          r_cnt     <= '0;
          r_run_max <= '0;
          r_done    <= 1'b1;
        end else begin
          r_cnt <= w_cnt_base + CNT_W'(1);
          if (w_take) r_run_max <= w_dark;
        end
      end
    end
  end

`ifdef ALE_IIR_EN
  localparam logic signed [PIX_W+1:0] LO_S = (PIX_W+2)'(A_MIN);
  localparam logic signed [PIX_W+1:0] HI_S = (PIX_W+2)'(A_TOP);

  logic             r_af_v;
  logic             r_have_prev;
  logic [PIX_W-1:0] r_af [3];

  // S3: clamped frame A, held for the smoothing stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_af_v      <= 1'b0;
      r_have_prev <= 1'b0;
      for (int c = 0; c < 3; c++) r_af[c] <= '0;
    end else begin
      r_af_v <= r_done;
      if (r_done) begin
        for (int c = 0; c < 3; c++) r_af[c] <= w_cl[c];
      end
      if (r_af_v) r_have_prev <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_iir
      logic signed [PIX_W:0]   w_diff;
      logic signed [PIX_W:0]   w_step;
      logic signed [PIX_W+1:0] w_sum;

      assign w_diff = $signed({1'b0, r_af[gi]}) - $signed({1'b0, r_a[gi]});
      assign w_step = w_diff >>> IIR_SH;
      assign w_sum  = $signed({2'b00, r_a[gi]}) + $signed({w_step[PIX_W], w_step});
      assign w_a_new[gi] = !r_have_prev  ? r_af[gi] :
                           (w_sum < LO_S) ? A_FLOOR :
                           (w_sum > HI_S) ? A_RST   : w_sum[PIX_W-1:0];
    end
  endgenerate

  assign w_commit = r_af_v;
`else
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_direct
      assign w_a_new[gi] = w_cl[gi];
    end
  endgenerate

  assign w_commit = r_done;
`endif

  // Final stage: A and its reciprocals update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        r_a[c]   <= A_RST;
        r_inv[c] <= INV_RST;
      end
    end else begin
      r_a_valid <= w_commit;
      if (w_commit) begin
        for (int c = 0; c < 3; c++) begin
          r_a[c]   <= w_a_new[c];
          r_inv[c] <= w_inv_new[c];
        end
      end
    end
  end

  assign a_r       = r_a[0];
  assign a_g       = r_a[1];
  assign a_b       = r_a[2];
  assign inv_a_r   = r_inv[0];
  assign inv_a_g   = r_inv[1];
  assign inv_a_b   = r_inv[2];
  assign a_valid   = r_a_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ale_frame_param.sv
// Directed bench for ale_frame_param on a 4x4 frame with 3x3 windows; honours ALE_IIR_EN.
module tb_ale_frame_param;

  localparam int PIX_W = 8;
  localparam int WIN   = 3;
  localparam int WBITS = WIN*WIN*3*PIX_W;
`ifdef ALE_IIR_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [WBITS-1:0] in_win = '0;
  logic [7:0]       a_r, a_g, a_b;
  logic [15:0]      inv_a_r, inv_a_g, inv_a_b;
  logic             a_valid, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_av = 0;
  int n_fe = 0;
  int av_cyc = -1;
  int last_drive_cyc = 0;

  ale_frame_param #(
    .IMG_W(4), .IMG_H(4), .PIX_W(PIX_W), .WIN(WIN), .A_MIN(16), .IIR_SH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_win(in_win),
    .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
    .a_valid(a_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid) begin
      n_av   = n_av + 1;
      av_cyc = cyc;
      $display("commit @%0d a=(%0d,%0d,%0d) inv=(%0d,%0d,%0d)", cyc, a_r, a_g, a_b,
               inv_a_r, inv_a_g, inv_a_b);
    end
    if (frame_err) begin
      n_fe = n_fe + 1;
      $display("frame_err @%0d", cyc);
    end
  end

  function automatic logic [WBITS-1:0] mk_win(input logic [23:0] rgb, input bit zpix);
    logic [WBITS-1:0] w;
    for (int k = 0; k < WIN*WIN; k++) w[k*24 +: 24] = (zpix && k == 4) ? 24'h0 : rgb;
    return w;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_win(input logic [23:0] rgb, input bit sof, input bit zpix);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; in_win = mk_win(rgb, zpix);
    last_drive_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (a_r !== 8'd255) begin n_errors++; $display("FAIL reset_a_r got %0d want 255", a_r); end
    if (a_b !== 8'd255) begin n_errors++; $display("FAIL reset_a_b got %0d want 255", a_b); end
    if (inv_a_r !== 16'd257) begin n_errors++; $display("FAIL reset_inv_r got %0d want 257", inv_a_r); end
    if (inv_a_g !== 16'd257) begin n_errors++; $display("FAIL reset_inv_g got %0d want 257", inv_a_g); end
    if (a_valid !== 1'b0) begin n_errors++; $display("FAIL reset_a_valid got %0b want 0", a_valid); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
  endtask

  task automatic test_uniform();
    int av0, fe0;
    do_reset();
    av0 = n_av; fe0 = n_fe;
    for (int i = 0; i < 16; i++) send_win({8'd200, 8'd180, 8'd160}, i == 0, 1'b0);
    idle(10);
    n_checks += 9;
    if (n_av - av0 !== 1) begin n_errors++; $display("FAIL t1_av_count got %0d want 1", n_av - av0); end
    if (av_cyc !== last_drive_cyc + LAT) begin n_errors++; $display("FAIL t1_latency got %0d want %0d", av_cyc, last_drive_cyc + LAT); end
    if (n_fe - fe0 !== 0) begin n_errors++; $display("FAIL t1_frame_err got %0d want 0", n_fe - fe0); end
    if (a_r !== 8'd200) begin n_errors++; $display("FAIL t1_a_r got %0d want 200", a_r); end
    if (a_g !== 8'd180) begin n_errors++; $display("FAIL t1_a_g got %0d want 180", a_g); end
    if (a_b !== 8'd160) begin n_errors++; $display("FAIL t1_a_b got %0d want 160", a_b); end
    if (inv_a_r !== 16'd327) begin n_errors++; $display("FAIL t1_inv_r got %0d want 327", inv_a_r); end
    if (inv_a_g !== 16'd364) begin n_errors++; $display("FAIL t1_inv_g got %0d want 364", inv_a_g); end
    if (inv_a_b !== 16'd409) begin n_errors++; $display("FAIL t1_inv_b got %0d want 409", inv_a_b); end
  endtask

  task automatic test_tie_raster();
    logic [23:0] rgb;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rgb = (i == 3) ? {8'd130, 8'd125, 8'd120} :
            (i == 9) ? {8'd240, 8'd230, 8'd120} : {8'd10, 8'd10, 8'd10};
      send_win(rgb, i == 0, 1'b0);
    end
    idle(10);
    n_checks += 4;
    if (a_r !== 8'd130) begin n_errors++; $display("FAIL t2_a_r got %0d want 130", a_r); end
    if (a_g !== 8'd125) begin n_errors++; $display("FAIL t2_a_g got %0d want 125", a_g); end
    if (a_b !== 8'd120) begin n_errors++; $display("FAIL t2_a_b got %0d want 120", a_b); end
    if (inv_a_r !== 16'd504) begin n_errors++; $display("FAIL t2_inv_r got %0d want 504", inv_a_r); end
  endtask

  task automatic test_clamp();
    int av0, fe0;
    do_reset();
    av0 = n_av; fe0 = n_fe;
    for (int i = 0; i < 16; i++) send_win({8'd5, 8'd5, 8'd5}, i == 0, 1'b0);
    idle(10);
    n_checks += 3;
    if (a_r !== 8'd16) begin n_errors++; $display("FAIL t3_a_r got %0d want 16", a_r); end
    if (a_g !== 8'd16) begin n_errors++; $display("FAIL t3_a_g got %0d want 16", a_g); end
    if (inv_a_b !== 16'd4096) begin n_errors++; $display("FAIL t3_inv_b got %0d want 4096", inv_a_b); end
    // Second frame follows with no start flag, relying on automatic re-arm.
    for (int i = 0; i < 16; i++) send_win({8'd90, 8'd90, 8'd90}, 1'b0, 1'b1);
    idle(10);
    n_checks += 4;
    if (n_av - av0 !== 2) begin n_errors++; $display("FAIL t3_av_count got %0d want 2", n_av - av0); end
    if (n_fe - fe0 !== 0) begin n_errors++; $display("FAIL t3_frame_err got %0d want 0", n_fe - fe0); end
    if (a_g !== 8'd16) begin n_errors++; $display("FAIL t3_zero_a_g got %0d want 16", a_g); end
    if (inv_a_r !== 16'd4096) begin n_errors++; $display("FAIL t3_zero_inv_r got %0d want 4096", inv_a_r); end
  endtask

  task automatic test_resync();
    int av0, fe0;
    do_reset();
    av0 = n_av; fe0 = n_fe;
    for (int i = 0; i < 7; i++) send_win({8'd255, 8'd255, 8'd255}, i == 0, 1'b0);
    for (int i = 0; i < 16; i++) send_win({8'd250, 8'd250, 8'd250}, i == 0, 1'b0);
    idle(10);
    n_checks += 4;
    if (n_fe - fe0 !== 1) begin n_errors++; $display("FAIL t4_frame_err got %0d want 1", n_fe - fe0); end
    if (n_av - av0 !== 1) begin n_errors++; $display("FAIL t4_av_count got %0d want 1", n_av - av0); end
    if (a_r !== 8'd250) begin n_errors++; $display("FAIL t4_a_r got %0d want 250", a_r); end
    if (inv_a_g !== 16'd262) begin n_errors++; $display("FAIL t4_inv_g got %0d want 262", inv_a_g); end
  endtask

  task automatic test_back_to_back();
    int av0;
    logic [7:0] exp2;
    logic [15:0] exp2_inv;
`ifdef ALE_IIR_EN
    exp2 = 8'd150; exp2_inv = 16'd436;
`else
    exp2 = 8'd200; exp2_inv = 16'd327;
`endif
    do_reset();
    av0 = n_av;
    for (int i = 0; i < 16; i++) begin
      send_win({8'd100, 8'd100, 8'd100}, i == 0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(10);
    n_checks += 3;
    if (n_av - av0 !== 1) begin n_errors++; $display("FAIL t5_av_first got %0d want 1", n_av - av0); end
    if (a_r !== 8'd100) begin n_errors++; $display("FAIL t5_a_first got %0d want 100", a_r); end
    if (inv_a_r !== 16'd655) begin n_errors++; $display("FAIL t5_inv_first got %0d want 655", inv_a_r); end
    for (int i = 0; i < 15; i++) begin
      send_win({8'd200, 8'd200, 8'd200}, i == 0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    n_checks += 2;
    if (n_av - av0 !== 1) begin n_errors++; $display("FAIL t5_hold_count got %0d want 1", n_av - av0); end
    if (a_g !== 8'd100) begin n_errors++; $display("FAIL t5_hold_a_g got %0d want 100", a_g); end
    send_win({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0);
    idle(10);
    n_checks += 4;
    if (n_av - av0 !== 2) begin n_errors++; $display("FAIL t5_av_second got %0d want 2", n_av - av0); end
    if (av_cyc !== last_drive_cyc + LAT) begin n_errors++; $display("FAIL t5_latency got %0d want %0d", av_cyc, last_drive_cyc + LAT); end
    if (a_b !== exp2) begin n_errors++; $display("FAIL t5_a_second got %0d want %0d", a_b, exp2); end
    if (inv_a_b !== exp2_inv) begin n_errors++; $display("FAIL t5_inv_second got %0d want %0d", inv_a_b, exp2_inv); end
  endtask

  task automatic test_reset_mid_frame();
    int av0;
    logic [7:0] exp2;
`ifdef ALE_IIR_EN
    exp2 = 8'd150;
`else
    exp2 = 8'd100;
`endif
    do_reset();
    for (int i = 0; i < 16; i++) send_win({8'd60, 8'd60, 8'd60}, i == 0, 1'b0);
    idle(10);
    av0 = n_av;
    for (int i = 0; i < 8; i++) send_win({8'd200, 8'd200, 8'd200}, i == 0, 1'b0);
    do_reset();
    // Remainder of the interrupted frame must not complete a commit.
    for (int i = 0; i < 8; i++) send_win({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0);
    idle(10);
    n_checks += 3;
    if (n_av - av0 !== 0) begin n_errors++; $display("FAIL t6_no_commit got %0d want 0", n_av - av0); end
    if (a_r !== 8'd255) begin n_errors++; $display("FAIL t6_a_r got %0d want 255", a_r); end
    if (inv_a_b !== 16'd257) begin n_errors++; $display("FAIL t6_inv_b got %0d want 257", inv_a_b); end
    do_reset();
    for (int i = 0; i < 16; i++) send_win({8'd200, 8'd200, 8'd200}, i == 0, 1'b0);
    idle(10);
    n_checks += 1;
    if (a_r !== 8'd200) begin n_errors++; $display("FAIL t6_iir_first got %0d want 200", a_r); end
    for (int i = 0; i < 16; i++) send_win({8'd100, 8'd100, 8'd100}, i == 0, 1'b0);
    idle(10);
    n_checks += 1;
    if (a_r !== exp2) begin n_errors++; $display("FAIL t6_iir_second got %0d want %0d", a_r, exp2); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_tie_raster();
    test_clamp();
    test_resync();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
